// File: rtl/decoder3to8_stream.sv
// Streaming 3-to-8 one-hot decoder with a 2-entry output FIFO, a self-test
// sweep mode and a wrapping output handshake counter.
module decoder3to8_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       code,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sweep_start,
  output logic [7:0]       out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {
    PASS,
    SWEEP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       sweep_idx_q, sweep_idx_d;
  logic [7:0]       head_q, head_d;
  logic [7:0]       tail_q, tail_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic             full;
  logic [7:0]       push_word;

  // in_ready depends only on registered state (plus reset), never on out_ready.
  assign full       = (fill_q == 2'd2);
  assign in_ready   = rst_n && (state_q == PASS) && !full;
  assign out_valid  = (fill_q != 2'd0);
  assign out_onehot = head_q;
  assign busy       = (state_q == SWEEP);
  assign count      = count_q;
  assign pop        = out_valid && out_ready;

  // A sweep request wins over a simultaneous input handshake.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    push        = 1'b0;
    push_word   = 8'h00;
    case (state_q)
      PASS: begin
        if (sweep_start) begin
          state_d     = SWEEP;
          sweep_idx_d = 3'd0;
        end else if (in_valid && in_ready) begin
          push      = 1'b1;
          push_word = en ? (8'h01 << code) : 8'h00;
        end
      end
      SWEEP: begin
        if (!full) begin
          push        = 1'b1;
          push_word   = 8'h01 << sweep_idx_q;
          sweep_idx_d = sweep_idx_q + 3'd1;
          if (sweep_idx_q == 3'd7) begin
            state_d = PASS;
          end
        end
      end
      default: state_d = PASS;
    endcase
  end

  // Unused slots are kept at zero so the head reads 8'h00 whenever empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = pop ? (count_q + CNT_ONE) : count_q;
    case ({push, pop})
      2'b10: begin
        if (fill_q == 2'd0) begin
          head_d = push_word;
        end else begin
          tail_d = push_word;
        end
        fill_d = fill_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        tail_d = 8'h00;
        fill_d = fill_q - 2'd1;
      end
      2'b11: begin
        if (fill_q == 2'd1) begin
          head_d = push_word;
        end else begin
          head_d = tail_q;
          tail_d = push_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PASS;
      sweep_idx_q <= 3'd0;
      head_q      <= 8'h00;
      tail_q      <= 8'h00;
      fill_q      <= 2'd0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_decoder3to8_stream.sv
// Scoreboard bench for decoder3to8_stream built with a 4-bit counter so the
// wrap can be reached quickly.
module tb_decoder3to8_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] code;
  logic       in_valid;
  logic       in_ready;
  logic       sweep_start;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [3:0] count;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  logic [3:0] exp_count = 4'd0;

  logic       s_ready;
  logic       s_valid;
  logic       s_out_hs;
  logic       s_busy;
  logic [7:0] s_word;
  logic [3:0] s_count;

  decoder3to8_stream #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .code       (code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sweep_start(sweep_start),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Samples at the falling edge, then moves to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_ready  = in_ready;
    s_valid  = out_valid;
    s_out_hs = out_valid && out_ready;
    s_busy   = busy;
    s_word   = out_onehot;
    s_count  = count;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; code = 3'd0; in_valid = 1'b0;
    sweep_start = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_onehot !== 8'h00) begin failures++; $display("[TB] FAIL reset_word: got %h want 00", out_onehot); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_held: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      code     = 3'(i);
      tick();
      if (i > 0) begin
        checks++; if (s_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_latency%0d: valid %b want 1", i, s_valid); end
      end
      if (s_out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL b2b_word: got %h with nothing expected", s_word); end
        else begin
          exp_w = exp_q.pop_front(); exp_count++;
          if (s_word !== exp_w) begin failures++; $display("[TB] FAIL b2b_word: got %h want %h", s_word, exp_w); end
        end
      end
      if (i < 8) begin
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, s_ready); end
        exp_q.push_back(8'h01 << i);
      end
    end
    tick();
    checks++; if (s_count !== 4'd8 || s_count !== exp_count) begin failures++; $display("[TB] FAIL b2b_count: got %0d want 8", s_count); end
    checks++; if (s_valid !== 1'b0 || s_word !== 8'h00) begin failures++; $display("[TB] FAIL b2b_empty: valid %b word %h want 0/00", s_valid, s_word); end
  endtask

  task automatic test_stall();
    logic exp_ready[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code = 3'(i + 1);
      tick();
      checks++; if (s_ready !== exp_ready[i]) begin failures++; $display("[TB] FAIL stall_ready%0d: got %b want %b", i, s_ready, exp_ready[i]); end
      if (i > 0) begin
        checks++; if (s_valid !== 1'b1 || s_word !== 8'h02) begin failures++; $display("[TB] FAIL stall_hold%0d: valid %b word %h want 1/02", i, s_valid, s_word); end
      end
      if (exp_ready[i]) exp_q.push_back(8'h01 << (i + 1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_full_pop_ready: got %b want 0", s_ready); end
      end
      if (s_out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL stall_word: got %h with nothing expected", s_word); end
        else begin
          exp_w = exp_q.pop_front(); exp_count++;
          if (s_word !== exp_w) begin failures++; $display("[TB] FAIL stall_word: got %h want %h", s_word, exp_w); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL stall_drain: %0d words left want 0", exp_q.size()); end
    checks++; if (s_count !== exp_count) begin failures++; $display("[TB] FAIL stall_count: got %0d want %0d", s_count, exp_count); end
  endtask

  task automatic test_disabled();
    en = 1'b0; code = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL dis_ready: got %b want 1", s_ready); end
    exp_q.push_back(8'h00);
    in_valid = 1'b0; en = 1'b1;
    tick();
    checks++; if (s_valid !== 1'b1) begin failures++; $display("[TB] FAIL dis_valid: got %b want 1", s_valid); end
    if (s_out_hs) begin
      checks++;
      exp_w = exp_q.pop_front(); exp_count++;
      if (s_word !== exp_w) begin failures++; $display("[TB] FAIL dis_word: got %h want %h", s_word, exp_w); end
    end
    tick();
    checks++; if (s_count !== exp_count) begin failures++; $display("[TB] FAIL dis_count: got %0d want %0d", s_count, exp_count); end
  endtask

  task automatic test_sweep();
    int m = 0;
    int idx = 0;
    int cyc = 0;
    bit sweeping = 1'b1;
    bit mpush;
    bit mpop;
    en = 1'b1; code = 3'd6; in_valid = 1'b1; sweep_start = 1'b1; out_ready = 1'b0;
    tick();
    checks++; if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL sweep_start_busy: got %b want 0", s_busy); end
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h01 << k);
    while ((sweeping || m > 0) && cyc < 100) begin
      out_ready   = 1'($urandom_range(0, 1));
      in_valid    = sweeping;
      sweep_start = sweeping && (idx == 3);
      tick();
      checks++; if (s_busy !== sweeping) begin failures++; $display("[TB] FAIL sweep_busy c%0d: got %b want %b", cyc, s_busy, sweeping); end
      checks++; if (s_ready !== (!sweeping && m < 2)) begin failures++; $display("[TB] FAIL sweep_ready c%0d: got %b", cyc, s_ready); end
      checks++; if (s_valid !== (m > 0)) begin failures++; $display("[TB] FAIL sweep_valid c%0d: got %b want %b", cyc, s_valid, (m > 0)); end
      if (s_out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL sweep_word: got %h with nothing expected", s_word); end
        else begin
          exp_w = exp_q.pop_front(); exp_count++;
          if (s_word !== exp_w) begin failures++; $display("[TB] FAIL sweep_word: got %h want %h", s_word, exp_w); end
        end
      end
      mpush = sweeping && (m < 2);
      mpop  = (m > 0) && out_ready;
      m = m + int'(mpush) - int'(mpop);
      if (mpush) begin
        idx++;
        if (idx == 8) sweeping = 1'b0;
      end
      cyc++;
    end
    sweep_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (cyc >= 100) begin failures++; $display("[TB] FAIL sweep_timeout: %0d cycles", cyc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL sweep_drain: %0d words left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_sweep();
    out_ready = 1'b0; in_valid = 1'b0; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (3) tick();
    checks++; if (s_valid !== 1'b1 || s_busy !== 1'b1 || s_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_sweep_pre: valid %b busy %b ready %b want 1/1/0", s_valid, s_busy, s_ready);
    end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin failures++; $display("[TB] FAIL rst_sweep_out: valid %b word %h want 0/00", out_valid, out_onehot); end
    checks++; if (busy !== 1'b0 || count !== 4'd0 || in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_sweep_state: busy %b count %0d ready %b want 0/0/0", busy, count, in_ready);
    end
    exp_q.delete();
    exp_count = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1 || s_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_sweep_release: ready %b busy %b want 1/0", s_ready, s_busy); end
    tick();
    checks++; if (s_valid !== 1'b0 || s_count !== 4'd0) begin failures++; $display("[TB] FAIL rst_sweep_leftover: valid %b count %0d want 0/0", s_valid, s_count); end
  endtask

  task automatic test_count_wrap();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      in_valid = (i < 16);
      code     = 3'(i % 8);
      tick();
      if (s_out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL wrap_word: got %h with nothing expected", s_word); end
        else begin
          exp_w = exp_q.pop_front(); exp_count++;
          if (s_word !== exp_w) begin failures++; $display("[TB] FAIL wrap_word: got %h want %h", s_word, exp_w); end
        end
      end
      if (i == 16) begin
        checks++; if (s_count !== 4'hF) begin failures++; $display("[TB] FAIL wrap_allones: got %0d want 15", s_count); end
      end
      if (i < 16) exp_q.push_back(8'h01 << (i % 8));
    end
    in_valid = 1'b0;
    tick();
    checks++; if (s_count !== 4'd0 || s_count !== exp_count) begin failures++; $display("[TB] FAIL wrap_zero: got %0d want 0", s_count); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_disabled();
    test_sweep();
    test_reset_mid_sweep();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
